nubus_arb_seq: RTL and testbench
================================

Name: nubus_arb_seq

Overview:
- Arbitration sequencer for the card's NuBus master path.
- Accepts a bus-tenure request from the local master state machine and drives the RQST line, timed to NuBus START/ACK activity.
- Enables the arbitration-line driver stage (ARBENA) and samples its GRANT result after the settle window.
- Hands bus ownership (OWNER) to the master until the master signals DONE; enforces NuBus fairness between tenures.

Parameters:
- ARB_CYCLES, 2, clocks ARBENA is held before GRANT is sampled (settle window); legal range 1..7.
- TMO_CYCLES, 255, arbitration watchdog limit in clocks; used only when the optional feature is compiled in.

Ports:
- CLK  in  1  NuBus-rate clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ  in  1  level request from local master; held until OWNER or withdrawn.
- DONE  in  1  one-cycle pulse from master: tenure finished.
- START_I  in  1  synchronized, active-high NuBus START observed this cycle.
- ACK_I  in  1  synchronized, active-high NuBus ACK observed this cycle.
- RQST_I  in  1  synchronized, active-high wired-OR RQST (includes own drive).
- GRANT  in  1  arbitration result from the ARB line stage.
- ARBENA  out  1  enables own ID onto ARB lines.
- RQST_O  out  1  drive RQST.
- OWNER  out  1  bus tenure granted to local master.
- ARB_TMO  out  1  one-cycle watchdog pulse; tied 0 when the feature is absent.

Behaviour:
- All outputs are registered. Reset values: ARBENA=0, RQST_O=0, OWNER=0, ARB_TMO=0, state=IDLE, bus_busy=0, fair_block=0, cnt=0.
- bus_busy tracks the bus transaction state:
  - START_I & ~ACK_I sets it.
  - ACK_I & ~START_I clears it.
  - START_I & ACK_I (attention cycle) leaves it unchanged.
- fair_block is set on the OWN->IDLE transition and cleared in any cycle with RQST_I=0. In the cycle that sets it, the set wins.
- States:
  - IDLE: outputs 0. On REQ & ~fair_block:
    - to ARB if ~bus_busy | START_I (RQST_O=1, ARBENA=1, cnt=0);
    - else to PEND (RQST_O=1).
  - PEND (also entered after a lost arbitration): RQST_O=1, ARBENA=0. On START_I, or on ~bus_busy with no START_I, go to ARB with cnt=0.
  - ARB: RQST_O=1, ARBENA=1, cnt increments each clock. When cnt==ARB_CYCLES-1, sample GRANT:
    - GRANT=1 -> WAIT_BUS;
    - GRANT=0 -> PEND (ARBENA drops next cycle).
    - Minimum ARBENA-to-decision latency is ARB_CYCLES clocks.
  - WAIT_BUS: RQST_O=1, ARBENA=1. Go to OWN when ACK_I & ~START_I, or when ~bus_busy & ~START_I.
  - OWN: OWNER=1, RQST_O=0, ARBENA=0. DONE -> IDLE, OWNER=0 next cycle. REQ is ignored while in OWN.
- Withdrawal: REQ=0 in PEND, ARB or WAIT_BUS returns to IDLE next clock with all outputs 0. fair_block is not set.
- DONE outside OWN is ignored.
- RESET asserted mid-tenure forces all outputs to 0 asynchronously; the master must treat loss of OWNER as an abort.

Optional Feature:
- Macro ARB_SEQ_TIMEOUT_EN.
- Defined: an 8-bit+ watchdog counter runs while the state is PEND, ARB or WAIT_BUS, and clears on any other state.
  - On reaching TMO_CYCLES: ARB_TMO pulses 1 for one cycle, the FSM returns to IDLE (outputs 0), and fair_block is set.
- Undefined: no counter; ARB_TMO constant 0; the FSM waits indefinitely.

Test Plan:
- Idle bus, ARB_CYCLES=2, REQ rises at cycle 0, GRANT=1 -> RQST_O/ARBENA=1 at cycle 1; GRANT sampled cycle 2; WAIT_BUS cycle 3; OWNER=1 cycle 4; DONE at cycle 8 -> OWNER=0 at cycle 9.
- Lost arbitration: GRANT=0 at sample -> ARBENA=0 next cycle, RQST_O stays 1; START_I pulse then ACK_I -> re-arbitrate, GRANT=1 -> OWNER asserts the cycle after ACK_I.
- Fairness: after DONE, REQ held with RQST_I=1 for 10 cycles -> RQST_O stays 0; RQST_I drops for 1 cycle -> RQST_O=1 within 2 cycles.
- Busy bus: bus_busy set by START_I; REQ -> PEND, ARBENA=0 until next START_I; simultaneous START_I&ACK_I leaves bus_busy unchanged.
- Withdrawal and reset: REQ dropped in ARB -> IDLE, outputs 0 next clock. RESET asserted in OWN -> OWNER=0 without a clock edge.
- With ARB_SEQ_TIMEOUT_EN, TMO_CYCLES=20, GRANT held 0 and the bus never idles -> ARB_TMO single pulse at the 20th cycle of the watchdog window, RQST_O=0 the next cycle.

Source files
------------

// File: rtl/nubus_arb_seq.sv
// nubus_arb_seq
// Arbitration sequencer for the card's NuBus master path. Takes a level
// request from the local master and raises RQST at a point that fits the
// observed START/ACK traffic. It then enables the ARB line driver for a settle
// window, samples GRANT, and waits for the bus to go idle. After that it gives
// OWNER to the master until DONE. A fairness latch blocks a new request after
// a tenure until RQST has been seen released on the bus.
//
// Optional feature, guarded by macro ARB_SEQ_TIMEOUT_EN:
//   Adds an arbitration watchdog. It pulses ARB_TMO and abandons the attempt
//   when the sequencer spends TMO_CYCLES clocks in PEND/ARB/WAIT_BUS. Without
//   the macro, ARB_TMO is tied low and the sequencer waits indefinitely.
//
// All outputs are registered. They are decoded from the next state, so each
// output changes on the same edge as the state it belongs to.

module nubus_arb_seq #(
  parameter int ARB_CYCLES = 2,
  parameter int TMO_CYCLES = 255
) (
  input  logic CLK,
  input  logic RESET,
  input  logic REQ,
  input  logic DONE,
  input  logic START_I,
  input  logic ACK_I,
  input  logic RQST_I,
  input  logic GRANT,
  output logic ARBENA,
  output logic RQST_O,
  output logic OWNER,
  output logic ARB_TMO
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PEND     = 3'd1,
    S_ARB      = 3'd2,
    S_WAIT_BUS = 3'd3,
    S_OWN      = 3'd4
  } state_t;

  // Last settle-window count value; GRANT is sampled while cnt equals this.
  localparam logic [2:0] ARB_LAST = 3'(ARB_CYCLES - 1);

  // Catch illegal parameter values at elaboration rather than in the field.
  if ((ARB_CYCLES < 1) || (ARB_CYCLES > 7)) begin : g_bad_arb_cycles
    $error("nubus_arb_seq: ARB_CYCLES must be in 1..7");
  end
  if ((TMO_CYCLES < 1) || (TMO_CYCLES > 65535)) begin : g_bad_tmo_cycles
    $error("nubus_arb_seq: TMO_CYCLES must be in 1..65535");
  end

  // Helpers that decode which outputs a given state drives.
  function automatic logic f_drives_rqst(input state_t s);
    logic v;
    case (s)
      S_PEND, S_ARB, S_WAIT_BUS: v = 1'b1;
      default:                   v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic logic f_drives_arbena(input state_t s);
    logic v;
    case (s)
      S_ARB, S_WAIT_BUS: v = 1'b1;
      default:           v = 1'b0;
    endcase
    return v;
  endfunction

  state_t     r_state;
  state_t     w_state_fsm;
  state_t     w_state_nxt;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;
  logic       r_bus_busy;
  logic       w_bus_busy_nxt;
  logic       r_fair_block;
  logic       w_fair_nxt;
  logic       w_fair_set_fsm;
  logic       w_fair_set;
  logic       w_tmo_hit;
  logic       w_arb_tmo_nxt;
  logic       r_arbena;
  logic       r_rqst_o;
  logic       r_owner;
  logic       r_arb_tmo;

`ifdef ARB_SEQ_TIMEOUT_EN
  localparam int WDT_W = (TMO_CYCLES > 255) ? 16 : 8;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(TMO_CYCLES - 1);

  logic [WDT_W-1:0] r_wdt;
  logic [WDT_W-1:0] w_wdt_nxt;

  // Watchdog: counts clocks spent trying to win the bus; expires on WDT_LAST.
  // The pulse is pre-computed from the next state so that ARB_TMO stays registered.
  always_comb begin
    w_wdt_nxt     = {WDT_W{1'b0}};
    w_tmo_hit     = 1'b0;
    w_arb_tmo_nxt = 1'b0;
    if (f_drives_rqst(r_state)) begin
      w_wdt_nxt = r_wdt + WDT_W'(1);
      w_tmo_hit = (r_wdt == WDT_LAST);
    end else begin
      w_wdt_nxt = {WDT_W{1'b0}};
      w_tmo_hit = 1'b0;
    end
    if (f_drives_rqst(w_state_nxt)) begin
      w_arb_tmo_nxt = (w_wdt_nxt == WDT_LAST);
    end else begin
      w_arb_tmo_nxt = 1'b0;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wdt <= {WDT_W{1'b0}};
    end else begin
      r_wdt <= w_wdt_nxt;
    end
  end
`else
  // Without the watchdog, no attempt is ever abandoned.
  always_comb begin
    w_tmo_hit     = 1'b0;
    w_arb_tmo_nxt = 1'b0;
  end
`endif

  // Track whether a NuBus transaction is in progress. An attention cycle
  // (START and ACK together) leaves the tracked state as it was.
  always_comb begin
    w_bus_busy_nxt = r_bus_busy;
    if (START_I && !ACK_I) begin
      w_bus_busy_nxt = 1'b1;
    end else if (ACK_I && !START_I) begin
      w_bus_busy_nxt = 1'b0;
    end else begin
      w_bus_busy_nxt = r_bus_busy;
    end
  end

  // Arbitration next-state logic and settle-window counter.
  always_comb begin
    w_state_fsm    = r_state;
    w_cnt_nxt      = 3'd0;
    w_fair_set_fsm = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (REQ && !r_fair_block) begin
          if (!r_bus_busy || START_I) begin
            w_state_fsm = S_ARB;
          end else begin
            w_state_fsm = S_PEND;
          end
        end else begin
          w_state_fsm = S_IDLE;
        end
      end
      S_PEND: begin
        if (!REQ) begin
          w_state_fsm = S_IDLE;
        end else if (START_I || !r_bus_busy) begin
          w_state_fsm = S_ARB;
        end else begin
          w_state_fsm = S_PEND;
        end
      end
      S_ARB: begin
        if (!REQ) begin
          w_state_fsm = S_IDLE;
        end else if (r_cnt == ARB_LAST) begin
          if (GRANT) begin
            w_state_fsm = S_WAIT_BUS;
          end else begin
            w_state_fsm = S_PEND;
          end
        end else begin
          w_state_fsm = S_ARB;
          w_cnt_nxt   = r_cnt + 3'd1;
        end
      end
      S_WAIT_BUS: begin
        if (!REQ) begin
          w_state_fsm = S_IDLE;
        end else if ((ACK_I && !START_I) || (!r_bus_busy && !START_I)) begin
          w_state_fsm = S_OWN;
        end else begin
          w_state_fsm = S_WAIT_BUS;
        end
      end
      S_OWN: begin
        if (DONE) begin
          w_state_fsm    = S_IDLE;
          w_fair_set_fsm = 1'b1;
        end else begin
          w_state_fsm = S_OWN;
        end
      end
      default: begin
        w_state_fsm = S_IDLE;
      end
    endcase
  end

  // A watchdog expiry overrides the normal transition and blocks the requester
  // the same way the end of a tenure does.
  always_comb begin
    w_state_nxt = w_state_fsm;
    w_fair_set  = w_fair_set_fsm;
    if (w_tmo_hit) begin
      w_state_nxt = S_IDLE;
      w_fair_set  = 1'b1;
    end else begin
      w_state_nxt = w_state_fsm;
      w_fair_set  = w_fair_set_fsm;
    end
  end

  // Fairness latch: set after our tenure, released once RQST is seen low.
  // If both happen in the same cycle, the set takes priority.
  always_comb begin
    w_fair_nxt = r_fair_block;
    if (w_fair_set) begin
      w_fair_nxt = 1'b1;
    end else if (!RQST_I) begin
      w_fair_nxt = 1'b0;
    end else begin
      w_fair_nxt = r_fair_block;
    end
  end

  // State, tracking flags and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_cnt        <= 3'd0;
      r_bus_busy   <= 1'b0;
      r_fair_block <= 1'b0;
      r_arbena     <= 1'b0;
      r_rqst_o     <= 1'b0;
      r_owner      <= 1'b0;
      r_arb_tmo    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_bus_busy   <= w_bus_busy_nxt;
      r_fair_block <= w_fair_nxt;
      r_arbena     <= f_drives_arbena(w_state_nxt);
      r_rqst_o     <= f_drives_rqst(w_state_nxt);
      r_owner      <= (w_state_nxt == S_OWN);
      r_arb_tmo    <= w_arb_tmo_nxt;
    end
  end

  assign ARBENA  = r_arbena;
  assign RQST_O  = r_rqst_o;
  assign OWNER   = r_owner;
  assign ARB_TMO = r_arb_tmo;

endmodule

// File: tb/tb_nubus_arb_seq.sv
// Testbench for nubus_arb_seq: directed per-cycle vectors feed a scoreboard
// queue; a negedge monitor pops and compares {ARBENA,RQST_O,OWNER,ARB_TMO}.
module tb_nubus_arb_seq;

`ifdef ARB_SEQ_TIMEOUT_EN
  localparam int TMO = 20;
`else
  localparam int TMO = 255;
`endif

  logic CLK = 1'b0;
  logic RESET;
  logic REQ = 1'b0, DONE = 1'b0, START_I = 1'b0, ACK_I = 1'b0;
  logic RQST_I = 1'b0, GRANT = 1'b0;
  logic ARBENA, RQST_O, OWNER, ARB_TMO;

  int n_checks = 0;
  int n_fail   = 0;
  int row_num  = 0;

  logic [3:0] exp_q[$];
  string      tag_q[$];
  int         row_q[$];

  nubus_arb_seq #(.ARB_CYCLES(2), .TMO_CYCLES(TMO)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .DONE(DONE), .START_I(START_I),
    .ACK_I(ACK_I), .RQST_I(RQST_I), .GRANT(GRANT), .ARBENA(ARBENA),
    .RQST_O(RQST_O), .OWNER(OWNER), .ARB_TMO(ARB_TMO)
  );

  always #5 CLK = ~CLK;

  // One cycle of stimulus; e is the expected {ARBENA,RQST_O,OWNER,ARB_TMO}
  // during this cycle, i.e. the result of all earlier rows.
  task automatic step(input logic req, input logic done, input logic st,
                      input logic ak, input logic rq, input logic gr,
                      input logic [3:0] e, input string tag);
    @(posedge CLK);
    #1;
    REQ = req; DONE = done; START_I = st; ACK_I = ak; RQST_I = rq; GRANT = gr;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    row_q.push_back(row_num);
    row_num++;
  endtask

  task automatic direct_check(input string tag, input logic [3:0] exp);
    logic [3:0] got;
    got = {ARBENA, RQST_O, OWNER, ARB_TMO};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {arbena,rqst_o,owner,arb_tmo}=%b expected %b", tag, got, exp);
    end
  endtask

  // Monitor: compare the DUT outputs against the queued expectation each cycle.
  always @(negedge CLK) begin : monitor
    logic [3:0] e;
    logic [3:0] got;
    string      t;
    int         r;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      r   = row_q.pop_front();
      got = {ARBENA, RQST_O, OWNER, ARB_TMO};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s row %0d: got {arbena,rqst_o,owner,arb_tmo}=%b expected %b",
                 t, r, got, e);
      end
    end
  end

  initial begin
    RESET = 1'b1;
    #12;
    direct_check("reset_state", 4'b0000);
    @(negedge CLK);
    RESET = 1'b0;

    // Idle bus, straight win: ARB at 1, sample at 2, WAIT_BUS at 3, OWN at 4.
    step(1,0,0,0,1,0, 4'b0000, "idle_req");
    step(1,0,0,0,1,0, 4'b1100, "arb_cnt0");
    step(1,0,0,0,1,1, 4'b1100, "arb_sample");
    step(1,0,0,0,1,0, 4'b1100, "wait_bus");
    for (int i = 0; i < 4; i++) step(1,0,0,0,1,0, 4'b0010, "own");
    step(1,1,0,0,1,0, 4'b0010, "own_done");
    // Fairness: REQ held while RQST seen high keeps us off the bus.
    for (int i = 0; i < 10; i++) step(1,0,0,0,1,0, 4'b0000, "fair_hold");
    step(1,0,0,0,0,0, 4'b0000, "fair_rqst_low");
    step(1,0,0,0,1,0, 4'b0000, "fair_cleared");
    // Lost arbitration with START during ARB making the bus busy.
    step(1,0,1,0,1,0, 4'b1100, "arb_start_busy");
    step(1,0,0,0,1,0, 4'b1100, "lost_sample");
    step(1,0,0,0,1,0, 4'b0100, "pend_busy");
    step(1,0,0,0,1,0, 4'b0100, "pend_busy");
    step(1,0,1,0,1,0, 4'b0100, "pend_start");
    step(1,0,0,0,1,0, 4'b1100, "rearb_cnt0");
    step(1,0,0,0,1,1, 4'b1100, "rearb_grant");
    step(1,0,0,0,1,0, 4'b1100, "wait_busy");
    step(1,0,0,1,1,0, 4'b1100, "wait_ack");
    // DONE with RQST low in the same cycle: the fairness set wins.
    step(1,1,0,0,0,0, 4'b0010, "own_after_ack");
    step(1,0,0,0,1,0, 4'b0000, "done_idle");
    step(0,0,1,0,0,0, 4'b0000, "set_wins_blocked");
    // Attention cycle leaves bus busy, so REQ goes to PEND.
    step(0,0,1,1,1,0, 4'b0000, "attention");
    step(1,0,0,0,1,0, 4'b0000, "idle_busy_req");
    step(1,0,0,0,1,0, 4'b0100, "pend_after_attn");
    step(1,0,1,0,1,0, 4'b0100, "pend_start2");
    // Withdrawal in ARB.
    step(0,0,0,0,1,0, 4'b1100, "arb_withdraw");
    step(1,0,0,0,1,0, 4'b0000, "withdrawn_idle");
    step(1,0,0,1,1,0, 4'b0100, "pend_no_fair");
    step(1,0,0,0,1,0, 4'b0100, "pend_bus_idle");
    step(1,0,0,0,1,0, 4'b1100, "arb3_cnt0");
    step(1,0,0,0,1,1, 4'b1100, "arb3_grant");
    step(1,0,0,0,1,0, 4'b1100, "wait3");
    step(1,0,0,0,1,0, 4'b0010, "own3");

    // Asynchronous reset in OWN drops OWNER without a clock edge.
    @(posedge CLK);
    #2;
    direct_check("own_before_reset", 4'b0010);
    RESET = 1'b1;
    #1;
    direct_check("async_reset", 4'b0000);
    REQ = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;

`ifdef ARB_SEQ_TIMEOUT_EN
    // Busy bus, GRANT always 0: watchdog fires on window cycle 20.
    step(1,0,1,0,1,0, 4'b0000, "tmo_start");
    step(1,0,0,0,1,0, 4'b1100, "tmo_arb");
    step(1,0,0,0,1,0, 4'b1100, "tmo_arb");
    for (int i = 0; i < 17; i++) step(1,0,0,0,1,0, 4'b0100, "tmo_pend");
    step(1,0,0,0,1,0, 4'b0101, "tmo_pulse");
    step(1,0,0,0,1,0, 4'b0000, "tmo_idle");
    step(1,0,0,0,1,0, 4'b0000, "tmo_fair");
`else
    step(0,0,0,0,1,0, 4'b0000, "post_reset_idle");
    step(0,0,0,0,1,0, 4'b0000, "post_reset_idle");
`endif

    repeat (2) @(negedge CLK);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
